// File: rtl/snoop_bus_arbiter.sv
// Round-robin owner arbiter for the shared snooping bus: grant one cycle after a sampled request,
// forced revoke after TIMEOUT held cycles, one idle turnaround cycle after every ownership.
module snoop_bus_arbiter #(
  parameter int NUM_MASTERS = 4,
  parameter int ERRWIDTH    = 2,
  parameter int TIMEOUT     = 64
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [NUM_MASTERS-1:0]          busRequest,
  input  logic [NUM_MASTERS-1:0]          releaseBus,
  output logic [NUM_MASTERS-1:0]          busAvailable,
  output logic [$clog2(NUM_MASTERS)-1:0]  grantId,
  output logic                            busBusy,
  output logic [NUM_MASTERS*ERRWIDTH-1:0] errFromBus
);

  localparam int IDW = $clog2(NUM_MASTERS);
  localparam int CW  = $clog2(TIMEOUT);
  localparam logic [ERRWIDTH-1:0] ERR_PROTO   = ERRWIDTH'(1);
  localparam logic [ERRWIDTH-1:0] ERR_TIMEOUT = ERRWIDTH'(2);

  typedef enum logic [1:0] {IDLE, OWNED, TURN} state_t;

  state_t                        state, state_n;
  logic [NUM_MASTERS-1:0]        avail_n;
  logic [IDW-1:0]                gid_n, ptr, ptr_n, ptr_adv, winner;
  logic                          busy_n;
  logic [CW-1:0]                 cnt, cnt_n;
  logic [NUM_MASTERS*ERRWIDTH-1:0] err_n;
  logic                          owner_rel, hold_expired, timeout_fire;

  // First requester at or after the round-robin pointer, wrapping.
  function automatic logic [IDW-1:0] pick(input logic [NUM_MASTERS-1:0] req,
                                          input logic [IDW-1:0] start);
    logic [IDW-1:0] w;
    logic [IDW-1:0] cand;
    w = start;
    for (int k = NUM_MASTERS - 1; k >= 0; k--) begin
      cand = IDW'((int'(start) + k) % NUM_MASTERS);
      if (req[cand]) w = cand;
    end
    return w;
  endfunction

  assign winner       = pick(busRequest, ptr);
  assign ptr_adv      = (grantId == IDW'(NUM_MASTERS - 1)) ? '0 : grantId + IDW'(1);
  assign owner_rel    = releaseBus[grantId];
  assign hold_expired = (cnt == CW'(TIMEOUT - 1));
  assign timeout_fire = (state == OWNED) && hold_expired && !owner_rel;

  // A release from anyone but the live owner is a protocol fault; the owner itself can only time out.
  for (genvar i = 0; i < NUM_MASTERS; i++) begin : g_err
    localparam logic [IDW-1:0] ID = IDW'(i);
    logic spur, tmo;
    assign spur = releaseBus[i] && !((state == OWNED) && (grantId == ID));
    assign tmo  = timeout_fire && (grantId == ID);
    assign err_n[i*ERRWIDTH +: ERRWIDTH] = tmo ? ERR_TIMEOUT : (spur ? ERR_PROTO : '0);
  end

  always_comb begin
    state_n = state;
    avail_n = busAvailable;
    gid_n   = grantId;
    busy_n  = busBusy;
    ptr_n   = ptr;
    cnt_n   = cnt;
    case (state)
      IDLE: begin
        if (|busRequest) begin
          state_n         = OWNED;
          avail_n         = '0;
          avail_n[winner] = 1'b1;
          gid_n           = winner;
          busy_n          = 1'b1;
          cnt_n           = '0;
        end
      end
      OWNED: begin
        cnt_n = cnt + CW'(1);
        if (owner_rel || hold_expired) begin
          state_n = TURN;
          avail_n = '0;
          busy_n  = 1'b0;
          ptr_n   = ptr_adv;
          cnt_n   = '0;
        end
      end
      TURN:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      busAvailable <= '0;
      grantId      <= '0;
      busBusy      <= 1'b0;
      ptr          <= '0;
      cnt          <= '0;
      errFromBus   <= '0;
    end else begin
      state        <= state_n;
      busAvailable <= avail_n;
      grantId      <= gid_n;
      busBusy      <= busy_n;
      ptr          <= ptr_n;
      cnt          <= cnt_n;
      errFromBus   <= err_n;
    end
  end

endmodule

// File: tb/tb_snoop_bus_arbiter.sv
// Bench for snoop_bus_arbiter: fixed vector table, corner-case sequences and random traffic
// checked each cycle against an owner/cooldown reference model.
module tb_snoop_bus_arbiter;

  localparam int N   = 4;
  localparam int TMO = 64;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] busRequest = '0;
  logic [3:0] releaseBus = '0;
  logic [3:0] busAvailable;
  logic [1:0] grantId;
  logic       busBusy;
  logic [7:0] errFromBus;

  int checks = 0;
  int errors = 0;

  snoop_bus_arbiter #(.NUM_MASTERS(N), .ERRWIDTH(2), .TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset), .busRequest(busRequest), .releaseBus(releaseBus),
    .busAvailable(busAvailable), .grantId(grantId), .busBusy(busBusy), .errFromBus(errFromBus)
  );

  always #5 clk = ~clk;

  // Reference model: who owns the bus, how long it has held it, idle cycles still owed.
  int         m_owner, m_ptr, m_held, m_cool;
  logic [1:0] m_err [N];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_owner = -1; m_ptr = 0; m_held = 0; m_cool = 0;
    for (int i = 0; i < N; i++) m_err[i] = 2'b00;
  endtask

  task automatic model_step(input logic [3:0] req, input logic [3:0] rel);
    int c;
    bit found;
    for (int i = 0; i < N; i++) m_err[i] = (rel[i] && i != m_owner) ? 2'b01 : 2'b00;
    if (m_owner >= 0) begin
      if (rel[m_owner[1:0]]) begin
        m_ptr = (m_owner + 1) % N; m_owner = -1; m_cool = 1;
      end else if (m_held == TMO - 1) begin
        m_err[m_owner] = 2'b10;
        m_ptr = (m_owner + 1) % N; m_owner = -1; m_cool = 1;
      end else begin
        m_held++;
      end
    end else if (m_cool > 0) begin
      m_cool--;
    end else if (req != 4'b0) begin
      found = 0;
      for (int k = 0; k < N; k++) begin
        c = (m_ptr + k) % N;
        if (!found && req[c[1:0]]) begin
          found = 1; m_owner = c; m_held = 0;
        end
      end
    end
  endtask

  task automatic compare_model();
    logic [3:0] ea;
    logic [7:0] ee;
    ea = (m_owner >= 0) ? (4'b0001 << m_owner) : 4'b0000;
    ee = {m_err[3], m_err[2], m_err[1], m_err[0]};
    check("model_avail", busAvailable, ea);
    check("model_busy", busBusy, (m_owner >= 0));
    check("model_err", errFromBus, ee);
    if (m_owner >= 0) check("model_gid", grantId, m_owner);
  endtask

  task automatic step(input logic [3:0] r, input logic [3:0] l);
    busRequest = r;
    releaseBus = l;
    @(posedge clk);
    #1;
    model_step(r, l);
    compare_model();
  endtask

  // Asserts reset between edges so the async clear is observed before any clock.
  task automatic pulse_reset();
    busRequest = '0;
    releaseBus = '0;
    #2 reset = 1'b1;
    #1;
    check("rst_avail", busAvailable, 4'b0);
    check("rst_busy", busBusy, 1'b0);
    check("rst_gid", grantId, 2'd0);
    check("rst_err", errFromBus, 8'h0);
    @(posedge clk);
    #1 reset = 1'b0;
    model_reset();
  endtask

  typedef struct packed {
    logic [3:0] req;
    logic [3:0] rel;
    logic [3:0] avail;
    logic       busy;
    logic [1:0] gid;
    logic [7:0] err;
  } vec_t;

  vec_t tbl [15];

  initial begin
    int order[$];
    int cyc, own, last_rel, n;
    logic [3:0] r, l, prev;
    bit lazy;

    tbl[0]  = '{4'b0001, 4'b0000, 4'b0001, 1'b1, 2'd0, 8'h00};
    tbl[1]  = '{4'b0000, 4'b0000, 4'b0001, 1'b1, 2'd0, 8'h00};
    tbl[2]  = '{4'b0010, 4'b0100, 4'b0001, 1'b1, 2'd0, 8'h10};
    tbl[3]  = '{4'b0010, 4'b0001, 4'b0000, 1'b0, 2'd0, 8'h00};
    tbl[4]  = '{4'b0010, 4'b0000, 4'b0000, 1'b0, 2'd0, 8'h00};
    tbl[5]  = '{4'b0010, 4'b0000, 4'b0010, 1'b1, 2'd1, 8'h00};
    tbl[6]  = '{4'b0000, 4'b0010, 4'b0000, 1'b0, 2'd0, 8'h00};
    tbl[7]  = '{4'b0000, 4'b1000, 4'b0000, 1'b0, 2'd0, 8'h40};
    tbl[8]  = '{4'b1001, 4'b0000, 4'b1000, 1'b1, 2'd3, 8'h00};
    tbl[9]  = '{4'b1001, 4'b0110, 4'b1000, 1'b1, 2'd3, 8'h14};
    tbl[10] = '{4'b0001, 4'b1001, 4'b0000, 1'b0, 2'd0, 8'h01};
    tbl[11] = '{4'b0001, 4'b0000, 4'b0000, 1'b0, 2'd0, 8'h00};
    tbl[12] = '{4'b0000, 4'b0000, 4'b0000, 1'b0, 2'd0, 8'h00};
    tbl[13] = '{4'b0100, 4'b0000, 4'b0100, 1'b1, 2'd2, 8'h00};
    tbl[14] = '{4'b0000, 4'b0100, 4'b0000, 1'b0, 2'd0, 8'h00};

    // Power-on reset
    model_reset();
    #3;
    check("por_avail", busAvailable, 4'b0);
    check("por_busy", busBusy, 1'b0);
    check("por_gid", grantId, 2'd0);
    check("por_err", errFromBus, 8'h0);
    @(posedge clk);
    #1 reset = 1'b0;

    for (int i = 0; i < 15; i++) begin
      step(tbl[i].req, tbl[i].rel);
      check($sformatf("vec%0d_avail", i), busAvailable, tbl[i].avail);
      check($sformatf("vec%0d_busy", i), busBusy, tbl[i].busy);
      check($sformatf("vec%0d_err", i), errFromBus, tbl[i].err);
      if (tbl[i].busy) check($sformatf("vec%0d_gid", i), grantId, tbl[i].gid);
    end

    // All four request continuously; each owner releases 3 cycles after its grant
    pulse_reset();
    prev = '0; own = 0; last_rel = -1; cyc = 0;
    while (order.size() < 5 && cyc < 200) begin
      l = (busBusy && own == 2) ? busAvailable : 4'b0;
      if (l != 4'b0) last_rel = cyc + 1;
      step(4'b1111, l);
      cyc++;
      if (busAvailable != 4'b0 && busAvailable != prev) begin
        order.push_back(int'(grantId));
        if (last_rel >= 0) check("rr_gap", cyc - last_rel, 2);
        own = 0;
      end else if (busBusy) begin
        own++;
      end
      prev = busAvailable;
    end
    check("rr_count", order.size(), 5);
    for (int i = 0; i < order.size(); i++) check($sformatf("rr_order%0d", i), order[i], i % 4);

    // Owner 2 never releases: forced revoke, timeout code, next grant to 3
    pulse_reset();
    step(4'b0100, 4'b0);
    check("tmo_grant", busAvailable, 4'b0100);
    n = 0;
    while (busAvailable[2] && n < 100) begin
      step(4'b1000, 4'b0);
      n++;
    end
    check("tmo_len", n, 64);
    check("tmo_err", errFromBus, 8'h20);
    step(4'b1000, 4'b0);
    check("tmo_err_1cyc", errFromBus, 8'h00);
    check("tmo_turn", busAvailable, 4'b0000);
    step(4'b1000, 4'b0);
    check("tmo_next", busAvailable, 4'b1000);

    // Release on the very last allowed cycle is a plain release
    pulse_reset();
    step(4'b0010, 4'b0);
    for (int k = 1; k < TMO; k++) step(4'b0000, 4'b0);
    check("edge_still_owned", busAvailable, 4'b0010);
    step(4'b0000, 4'b0010);
    check("edge_rel_avail", busAvailable, 4'b0000);
    check("edge_rel_err", errFromBus, 8'h00);

    // Reset while master 3 owns with ptr moved away from 0
    pulse_reset();
    step(4'b0010, 4'b0);
    step(4'b0000, 4'b0010);
    step(4'b0000, 4'b0);
    step(4'b1000, 4'b0);
    check("pre_rst_owner", busAvailable, 4'b1000);
    step(4'b1000, 4'b0);
    pulse_reset();
    step(4'b1010, 4'b0);
    check("post_rst_ptr", busAvailable, 4'b0010);
    step(4'b0000, 4'b0010);
    step(4'b0000, 4'b0);
    step(4'b1000, 4'b0);
    check("post_rst_grant3", busAvailable, 4'b1000);

    // Random traffic, with lazy phases that let owners run into the timeout
    pulse_reset();
    r = '0; lazy = 0;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 3) == 0) r = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 199) == 0) lazy = !lazy;
      l = '0;
      for (int i = 0; i < N; i++) begin
        if (i == m_owner) l[i] = lazy ? ($urandom_range(0, 99) == 0) : ($urandom_range(0, 9) == 0);
        else              l[i] = ($urandom_range(0, 39) == 0);
      end
      step(r, l);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog expired");
  end

endmodule
